// File: rtl/sine_pkg.sv
// Shared defaults and fetch-FSM encoding for the sine-PWM read side.
package sine_pkg;

    localparam int SINE_ADDR_W  = 4;
    localparam int SINE_DATA_W  = 8;
    localparam int SINE_PHASE_W = 16;
    localparam int SINE_ROM_LAT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sine_pwm_gen.sv
// Phase-accumulator ROM sequencer with double-buffered PWM duty.
// One ROM fetch per PWM period; duty only changes at a period boundary.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for period start (en & cnt==0)
//   WAIT    | ROM read in flight, ROM_LAT+1 cycles, captures douta on exit
//   CAPTURE | sample holds the new value; sample_valid high this cycle
module sine_pwm_gen
    import sine_pkg::*;
#(
    parameter int ADDR_W  = SINE_ADDR_W,
    parameter int DATA_W  = SINE_DATA_W,
    parameter int PHASE_W = SINE_PHASE_W,
    parameter int ROM_LAT = SINE_ROM_LAT
) (
    input  logic               clka,
    input  logic               rsta,
    input  logic               en,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [ADDR_W-1:0]  addra,
    input  logic [DATA_W-1:0]  douta,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               period_tick,
    output logic               pwm_out
);

    localparam int WAIT_W = $clog2(ROM_LAT + 2);

    // The fetch must finish before the next period start can arrive.
    if (2**DATA_W <= ROM_LAT + 3) begin : g_bad_cfg
        $error("sine_pwm_gen: PWM period too short for ROM latency");
    end

    logic [DATA_W-1:0]  cnt;
    logic [DATA_W-1:0]  duty;
    logic [PHASE_W-1:0] phase;
    logic [WAIT_W-1:0]  wcnt;
    logic               load_sample;
    fetch_state_e       state, state_nxt;

    assign period_tick  = en & ~rsta & (cnt == '0);
    assign sample_valid = (state == CAPTURE);
    assign pwm_out      = en & (cnt < duty);

    always_ff @(posedge clka) begin
        if (rsta) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_sample = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cnt == '0) state_nxt = WAIT;
                WAIT:    if (wcnt == '0) begin
                             state_nxt   = CAPTURE;
                             load_sample = 1'b1;
                         end
                CAPTURE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            cnt    <= '0;
            duty   <= '0;
            phase  <= '0;
            wcnt   <= '0;
            addra  <= '0;
            sample <= '0;
        end else begin
            if (!en) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (period_tick) begin
                duty  <= sample;
                addra <= phase[PHASE_W-1 -: ADDR_W];
                phase <= phase + phase_inc;
                wcnt  <= WAIT_W'(ROM_LAT);
            end else if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end

            if (load_sample) begin
                sample <= douta;
            end
        end
    end

endmodule

// File: tb/tb_sine_pwm_gen.sv
// Directed bench for sine_pwm_gen with a 1-cycle ROM model (table[i]=16*i, entry 15 = 255).
module tb_sine_pwm_gen;

    logic        clka = 1'b0;
    logic        rsta;
    logic        en;
    logic [15:0] phase_inc;
    logic [3:0]  addra;
    logic [7:0]  douta;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        period_tick;
    logic        pwm_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] inc;
        int          addr;
        int          smp;
        int          hi;
    } vec_t;

    vec_t vecs[24];

    sine_pwm_gen dut (
        .clka         (clka),
        .rsta         (rsta),
        .en           (en),
        .phase_inc    (phase_inc),
        .addra        (addra),
        .douta        (douta),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_tick  (period_tick),
        .pwm_out      (pwm_out)
    );

    always #5 clka = ~clka;

    function automatic logic [7:0] rom_val(input int a);
        if (a == 15) return 8'd255;
        return 8'(16 * a);
    endfunction

    always @(posedge clka) douta <= rom_val(int'(addra));

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one PWM period starting at a period_tick cycle. The pwm window is
    // cnt 1..255 plus cnt 0 of the next period, the span during which the new
    // duty is in force. Returns with the bench sitting on the next tick cycle.
    task automatic do_period(input logic [15:0] inc, output int addr, output int off,
                             output int nsv, output int smp, output int hi);
        int budget = 600;
        while (!period_tick && budget > 0) begin
            step();
            budget--;
        end
        chk("tick_wait", int'(period_tick), 1);
        phase_inc = inc;
        hi = 0; off = -1; nsv = 0; smp = -1; addr = -1;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 1) addr = int'(addra);
            if (k < 256 && sample_valid) begin
                nsv++;
                off = k;
                smp = int'(sample);
            end
            hi += int'(pwm_out);
        end
    endtask

    task automatic check_period(input string tag, input logic [15:0] inc, input int e_addr,
                                input int e_smp, input int e_hi);
        int addr, off, nsv, smp, hi;
        do_period(inc, addr, off, nsv, smp, hi);
        chk({tag, "_addr"}, addr, e_addr);
        chk({tag, "_sv_cnt"}, nsv, 1);
        chk({tag, "_sv_off"}, off, 3);
        chk({tag, "_sample"}, smp, e_smp);
        chk({tag, "_pwm_hi"}, hi, e_hi);
    endtask

    initial begin
        int sv_seen;
        int tick_seen;

        vecs[0]  = '{16'h1000,  0,   0,   0};
        vecs[1]  = '{16'h1000,  1,  16,   0};
        vecs[2]  = '{16'h1000,  2,  32,  16};
        vecs[3]  = '{16'h1000,  3,  48,  32};
        vecs[4]  = '{16'h1000,  4,  64,  48};
        vecs[5]  = '{16'h1000,  5,  80,  64};
        vecs[6]  = '{16'h1000,  6,  96,  80};
        vecs[7]  = '{16'h1000,  7, 112,  96};
        vecs[8]  = '{16'h1000,  8, 128, 112};
        vecs[9]  = '{16'h1000,  9, 144, 128};
        vecs[10] = '{16'h1000, 10, 160, 144};
        vecs[11] = '{16'h1000, 11, 176, 160};
        vecs[12] = '{16'h1000, 12, 192, 176};
        vecs[13] = '{16'h1000, 13, 208, 192};
        vecs[14] = '{16'h1000, 14, 224, 208};
        vecs[15] = '{16'h1000, 15, 255, 224};
        vecs[16] = '{16'h1000,  0,   0, 255};
        vecs[17] = '{16'h0800,  1,  16,   0};
        vecs[18] = '{16'h0800,  1,  16,  16};
        vecs[19] = '{16'h0800,  2,  32,  16};
        vecs[20] = '{16'h0800,  2,  32,  32};
        vecs[21] = '{16'h0000,  3,  48,  32};
        vecs[22] = '{16'h0000,  3,  48,  48};
        vecs[23] = '{16'h0000,  3,  48,  48};

        rsta = 1'b1;
        en = 1'b1;
        phase_inc = 16'h0000;

        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rst%0d_addra", c), int'(addra), 0);
            chk($sformatf("rst%0d_pwm", c), int'(pwm_out), 0);
            chk($sformatf("rst%0d_sample", c), int'(sample), 0);
            chk($sformatf("rst%0d_sv", c), int'(sample_valid), 0);
            chk($sformatf("rst%0d_tick", c), int'(period_tick), 0);
        end
        rsta = 1'b0;
        #1;

        for (int i = 0; i < 24; i++) begin
            check_period($sformatf("p%0d", i), vecs[i].inc, vecs[i].addr, vecs[i].smp, vecs[i].hi);
        end

        // en dropped one cycle after period_tick, fetch of address 3 in flight
        chk("drop_tick", int'(period_tick), 1);
        phase_inc = 16'h1000;
        step();
        chk("drop_addra", int'(addra), 3);
        en = 1'b0;
        #1;
        chk("drop_pwm_now", int'(pwm_out), 0);
        sv_seen = 0;
        tick_seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            sv_seen += int'(sample_valid);
            tick_seen += int'(period_tick);
            sv_seen += 2 * int'(pwm_out);
        end
        chk("drop_no_sv_or_pwm", sv_seen, 0);
        chk("drop_no_tick", tick_seen, 0);
        chk("drop_sample_kept", int'(sample), 48);
        en = 1'b1;
        #1;
        chk("reen_tick_now", int'(period_tick), 1);
        check_period("reen", 16'h1000, 4, 64, 48);

        // reset two cycles after period_tick, fetch of address 5 in flight
        phase_inc = 16'h1000;
        step();
        step();
        rsta = 1'b1;
        step();
        chk("mrst_addra", int'(addra), 0);
        chk("mrst_sample", int'(sample), 0);
        chk("mrst_sv", int'(sample_valid), 0);
        chk("mrst_pwm", int'(pwm_out), 0);
        chk("mrst_tick", int'(period_tick), 0);
        step();
        chk("mrst_sv2", int'(sample_valid), 0);
        rsta = 1'b0;
        #1;
        check_period("post_rst0", 16'h1000, 0, 0, 0);
        check_period("post_rst1", 16'h1000, 1, 16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
